// File: rtl/control_sequencer_if.sv
// Bundle between the LEGv8 control sequencer, instruction/data memory handshakes and decoder bank.
// The sequencer owns the master side; memories/decoder/datapath sit on the slave side.
interface control_sequencer_if;
   logic        run;
   logic [31:0] instr_in;
   logic        imem_ack;
   logic        imem_req;
   logic        dmem_ready;
   logic [30:0] dec_cw;
   logic [1:0]  dec_next;
   logic [63:0] dec_k;
   logic [31:0] ir;
   logic [1:0]  state;
   logic [30:0] controlword;
   logic [63:0] K;
   logic        retire;
   logic        fault;

   modport master (
      input  run, instr_in, imem_ack, dmem_ready, dec_cw, dec_next, dec_k,
      output imem_req, ir, state, controlword, K, retire, fault
   );

   modport slave (
      output run, instr_in, imem_ack, dmem_ready, dec_cw, dec_next, dec_k,
      input  imem_req, ir, state, controlword, K, retire, fault
   );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle LEGv8 control sequencer: fetch into ir, step the decoder bank, and gate the
// controlword so nothing is written or steered while fetching, stalled on memory, or faulted.
module control_sequencer #(
   parameter int TIMEOUT   = 16,
   parameter int MAX_STEPS = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   control_sequencer_if.master  bus
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int SW = $clog2(MAX_STEPS + 1);
   localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT - 1);
   localparam logic [SW-1:0] STEP_LAST = SW'(MAX_STEPS - 1);

   typedef enum logic [1:0] {FETCH, EXEC, FAULT} fsm_t;

   fsm_t          fsm_reg;
   logic [31:0]   ir_reg;
   logic [1:0]    state_reg;
   logic [SW-1:0] step_reg;
   logic [TW-1:0] tout_reg;

   logic mem_op;
   logic stall;

   assign mem_op = bus.dec_cw[7] | bus.dec_cw[6];
   assign stall  = (fsm_reg == EXEC) && mem_op && !bus.dmem_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fsm_reg   <= FETCH;
         ir_reg    <= '0;
         state_reg <= '0;
         step_reg  <= '0;
         tout_reg  <= '0;
      end else begin
         case (fsm_reg)
            FETCH: begin
               if (!bus.run) begin
                  tout_reg <= '0;
               end else if (bus.imem_ack) begin
                  ir_reg    <= bus.instr_in;
                  state_reg <= '0;
                  step_reg  <= '0;
                  tout_reg  <= '0;
                  fsm_reg   <= EXEC;
               end else if (tout_reg == TOUT_LAST) begin
                  fsm_reg <= FAULT;
               end else begin
                  tout_reg <= tout_reg + 1'b1;
               end
            end
            EXEC: begin
               // A memory stall freezes the step: it neither advances state nor uses up a step.
               if (!stall) begin
                  if (bus.dec_next == 2'b00) begin
                     state_reg <= '0;
                     fsm_reg   <= FETCH;
                  end else if (step_reg == STEP_LAST) begin
                     fsm_reg <= FAULT;
                  end else begin
                     state_reg <= bus.dec_next;
                     step_reg  <= step_reg + 1'b1;
                  end
               end
            end
            FAULT: ;
            default: fsm_reg <= FAULT;
         endcase
      end
   end

   // Outputs derive from the asynchronously reset FSM, so a reset mid-EXEC zeroes them at once.
   always_comb begin
      bus.controlword = '0;
      bus.K           = '0;
      bus.retire      = 1'b0;
      if (fsm_reg == EXEC) begin
         bus.K = bus.dec_k;
         if (stall) begin
            bus.controlword = {2'b00, bus.dec_cw[28:9], 2'b00, bus.dec_cw[6:0]};
         end else begin
            bus.controlword = bus.dec_cw;
            bus.retire      = (bus.dec_next == 2'b00);
         end
      end
   end

   assign bus.imem_req = reset && (fsm_reg == FETCH) && bus.run;
   assign bus.fault    = (fsm_reg == FAULT);
   assign bus.ir       = ir_reg;
   assign bus.state    = state_reg;
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: the bench plays memory and decoder bank, drives inputs on
// the falling edge and checks outputs 1 ns later, with hand-computed expected values.
module tb_control_sequencer;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   control_sequencer_if bus();

   control_sequencer #(.TIMEOUT(16), .MAX_STEPS(4)) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end else begin
         $display("ok   %s = %h", tag, got);
      end
   endtask

   // Advance to the next falling edge, where new inputs are applied.
   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic settle();
      #1;
   endtask

   localparam logic [30:0] CW1      = 31'h2108_3128;
   localparam logic [30:0] CW2      = 31'h2123_4548;
   localparam logic [30:0] CW2_STL  = 31'h0123_4448;
   localparam logic [30:0] CW_PLAIN = 31'h0000_0028;
   localparam logic [30:0] CW6      = 31'h0000_00A8;

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.run = 1'b0; bus.instr_in = '0; bus.imem_ack = 1'b0; bus.dmem_ready = 1'b0;
      bus.dec_cw = '0; bus.dec_next = '0; bus.dec_k = '0;

      // Reset state
      next_cycle(); next_cycle();
      bus.run = 1'b1; bus.dec_cw = CW1; bus.dec_k = 64'hFFFF;
      settle();
      check_val("rst_ir", 64'(bus.ir), 64'h0);
      check_val("rst_state", 64'(bus.state), 64'h0);
      check_val("rst_cw", 64'(bus.controlword), 64'h0);
      check_val("rst_k", bus.K, 64'h0);
      check_val("rst_req", 64'(bus.imem_req), 64'h0);
      check_val("rst_fault_retire", 64'({bus.fault, bus.retire}), 64'h0);

      // 1: ADDI fetched on first FETCH cycle, 1-step instruction
      next_cycle();
      rst_n = 1'b1;
      bus.imem_ack = 1'b1; bus.instr_in = 32'h9100_0C41; bus.dec_next = 2'b00; bus.dec_k = 64'h3;
      settle();
      check_val("t1_req", 64'(bus.imem_req), 64'h1);
      check_val("t1_fetch_cw", 64'(bus.controlword), 64'h0);
      next_cycle();
      bus.imem_ack = 1'b0;
      settle();
      check_val("t1_ir", 64'(bus.ir), 64'h9100_0C41);
      check_val("t1_cw", 64'(bus.controlword), 64'(CW1));
      check_val("t1_k", bus.K, 64'h3);
      check_val("t1_retire", 64'(bus.retire), 64'h1);
      check_val("t1_req_exec", 64'(bus.imem_req), 64'h0);

      // 2: memory op stalled 3 cycles
      next_cycle();
      bus.imem_ack = 1'b1; bus.instr_in = 32'hF840_0000;
      settle();
      check_val("t2_fetch_retire", 64'(bus.retire), 64'h0);
      check_val("t2_fetch_k", bus.K, 64'h0);
      check_val("t2_fetch_req", 64'(bus.imem_req), 64'h1);
      next_cycle();
      bus.imem_ack = 1'b0; bus.dec_cw = CW2; bus.dmem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         check_val($sformatf("t2_stall_cw%0d", i), 64'(bus.controlword), 64'(CW2_STL));
         check_val($sformatf("t2_stall_ret%0d", i), 64'(bus.retire), 64'h0);
         check_val($sformatf("t2_stall_st%0d", i), 64'(bus.state), 64'h0);
         next_cycle();
      end
      bus.dmem_ready = 1'b1;
      settle();
      check_val("t2_cw", 64'(bus.controlword), 64'(CW2));
      check_val("t2_retire", 64'(bus.retire), 64'h1);

      // 3: three-step instruction 01,10,00
      next_cycle();
      bus.imem_ack = 1'b1; bus.instr_in = 32'h1234_5678;
      next_cycle();
      bus.imem_ack = 1'b0; bus.dec_cw = CW_PLAIN; bus.dec_next = 2'b01;
      settle();
      check_val("t3_st0", 64'({bus.state, bus.retire}), 64'({2'b00, 1'b0}));
      next_cycle();
      bus.dec_next = 2'b10;
      settle();
      check_val("t3_st1", 64'({bus.state, bus.retire}), 64'({2'b01, 1'b0}));
      next_cycle();
      bus.dec_next = 2'b00;
      settle();
      check_val("t3_st2", 64'({bus.state, bus.retire}), 64'({2'b10, 1'b1}));
      next_cycle();
      settle();
      check_val("t3_req_after", 64'(bus.imem_req), 64'h1);

      // 6a: run dropped mid-EXEC, instruction still retires
      bus.imem_ack = 1'b1;
      next_cycle();
      bus.imem_ack = 1'b0; bus.run = 1'b0; bus.dec_next = 2'b01;
      next_cycle();
      bus.dec_next = 2'b00;
      settle();
      check_val("t6_retire", 64'(bus.retire), 64'h1);
      next_cycle();
      settle();
      check_val("t6_req_paused", 64'(bus.imem_req), 64'h0);
      next_cycle();
      settle();
      check_val("t6_still_fetch", 64'(bus.controlword), 64'h0);
      bus.run = 1'b1;
      settle();
      check_val("t6_req_resume", 64'(bus.imem_req), 64'h1);

      // 6b: reset pulsed mid-EXEC with ramW=1
      bus.imem_ack = 1'b1;
      next_cycle();
      bus.imem_ack = 1'b0; bus.dec_cw = CW6; bus.dmem_ready = 1'b1; bus.dec_next = 2'b01;
      settle();
      check_val("t6_ramw_cw", 64'(bus.controlword), 64'(CW6));
      #2 rst_n = 1'b0;
      #1;
      check_val("t6_rst_cw", 64'(bus.controlword), 64'h0);
      check_val("t6_rst_ir", 64'(bus.ir), 64'h0);

      // 5: dec_next stuck at 01 -> fault after 4 EXEC cycles
      next_cycle();
      rst_n = 1'b1;
      bus.imem_ack = 1'b1; bus.dec_cw = CW_PLAIN; bus.dec_next = 2'b01;
      next_cycle();
      bus.imem_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         settle();
         check_val($sformatf("t5_exec%0d", i), 64'({bus.fault, bus.retire}), 64'h0);
         next_cycle();
      end
      settle();
      check_val("t5_fault", 64'(bus.fault), 64'h1);
      check_val("t5_fault_cw", 64'(bus.controlword), 64'h0);

      // 4: no imem_ack -> fault after 16 FETCH cycles
      rst_n = 1'b0;
      next_cycle();
      rst_n = 1'b1; bus.run = 1'b1; bus.imem_ack = 1'b0; bus.dec_cw = CW1;
      settle();
      check_val("t4_fault_c0", 64'(bus.fault), 64'h0);
      for (int i = 1; i <= 16; i++) begin
         next_cycle();
         settle();
         if (i >= 15) check_val($sformatf("t4_fault_c%0d", i), 64'(bus.fault), 64'(i >= 16));
      end
      bus.imem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         settle();
         check_val($sformatf("t4_hold%0d", i), 64'({bus.fault, bus.controlword, bus.imem_req}),
                   64'({1'b1, 31'h0, 1'b0}));
      end
      rst_n = 1'b0;
      settle();
      check_val("t4_reset_clears", 64'(bus.fault), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
